// File: rtl/sram22_rr_arbiter.sv
// Two-port arbiter in front of a single-port sram22 macro: valid/ready requests, 1-cycle read responses.
// Optional build macro SRAM22_ARB_FIXED_PRIO_EN: port 0 always wins contention (no round-robin pointer).
module sram22_rr_arbiter #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  p0_req_valid,
    output logic                  p0_req_ready,
    input  logic                  p0_req_we,
    input  logic [ADDR_WIDTH-1:0] p0_req_addr,
    input  logic [DATA_WIDTH-1:0] p0_req_wdata,
    output logic                  p0_rsp_valid,
    output logic [DATA_WIDTH-1:0] p0_rsp_rdata,
    input  logic                  p1_req_valid,
    output logic                  p1_req_ready,
    input  logic                  p1_req_we,
    input  logic [ADDR_WIDTH-1:0] p1_req_addr,
    input  logic [DATA_WIDTH-1:0] p1_req_wdata,
    output logic                  p1_rsp_valid,
    output logic [DATA_WIDTH-1:0] p1_rsp_rdata,
    output logic                  sram_we,
    output logic                  sram_wmask,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_din,
    input  logic [DATA_WIDTH-1:0] sram_dout
);

    logic                  gnt0;
    logic                  gnt1;
    logic                  gnt_any;
    logic                  gnt_we;
    logic [ADDR_WIDTH-1:0] gnt_addr;
    logic [DATA_WIDTH-1:0] gnt_wdata;
    logic [ADDR_WIDTH-1:0] held_addr;
    logic [DATA_WIDTH-1:0] held_din;
    logic                  rsp_pend;
    logic                  rsp_port;

`ifdef SRAM22_ARB_FIXED_PRIO_EN
    assign gnt0 = p0_req_valid;
    assign gnt1 = p1_req_valid && !p0_req_valid;
`else
    // rr_ptr names the port that wins the next contended cycle
    logic rr_ptr;

    assign gnt0 = p0_req_valid && (!p1_req_valid || !rr_ptr);
    assign gnt1 = p1_req_valid && (!p0_req_valid || rr_ptr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (gnt0) begin
            rr_ptr <= 1'b1;
        end else if (gnt1) begin
            rr_ptr <= 1'b0;
        end
    end
`endif

    assign gnt_any      = gnt0 || gnt1;
    assign p0_req_ready = gnt0;
    assign p1_req_ready = gnt1;

    // Idle cycles keep the macro address/data bus parked on the last granted values
    always_comb begin
        gnt_we    = 1'b0;
        gnt_addr  = held_addr;
        gnt_wdata = held_din;
        if (gnt0) begin
            gnt_we    = p0_req_we;
            gnt_addr  = p0_req_addr;
            gnt_wdata = p0_req_wdata;
        end else if (gnt1) begin
            gnt_we    = p1_req_we;
            gnt_addr  = p1_req_addr;
            gnt_wdata = p1_req_wdata;
        end
    end

    assign sram_we    = gnt_we;
    assign sram_wmask = gnt_we;
    assign sram_addr  = gnt_addr;
    assign sram_din   = gnt_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_addr <= '0;
            held_din  <= '0;
        end else if (gnt_any) begin
            held_addr <= gnt_addr;
            held_din  <= gnt_wdata;
        end
    end

    // A write grant never sets rsp_pend, so the X dout after a write is never forwarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_pend <= 1'b0;
            rsp_port <= 1'b0;
        end else begin
            rsp_pend <= gnt_any && !gnt_we;
            rsp_port <= gnt1;
        end
    end

    assign p0_rsp_valid = rsp_pend && !rsp_port;
    assign p1_rsp_valid = rsp_pend && rsp_port;
    assign p0_rsp_rdata = p0_rsp_valid ? sram_dout : '0;
    assign p1_rsp_rdata = p1_rsp_valid ? sram_dout : '0;

endmodule

// File: tb/tb_sram22_rr_arbiter.sv
// Randomized self-checking bench for sram22_rr_arbiter with a behavioural macro and reference model.
// Honours SRAM22_ARB_FIXED_PRIO_EN so the same bench checks either build.
module tb_sram22_rr_arbiter;
    localparam int DW = 24;
    localparam int AW = 6;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          p0_req_valid, p0_req_ready, p0_req_we, p0_rsp_valid;
    logic [AW-1:0] p0_req_addr;
    logic [DW-1:0] p0_req_wdata, p0_rsp_rdata;
    logic          p1_req_valid, p1_req_ready, p1_req_we, p1_rsp_valid;
    logic [AW-1:0] p1_req_addr;
    logic [DW-1:0] p1_req_wdata, p1_rsp_rdata;
    logic          sram_we, sram_wmask;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din, sram_dout;

    sram22_rr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
        .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
        .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
        .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
        .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
        .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural sram22 macro: 1-cycle sync read, dout is garbage in the cycle after a write
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (sram_we && sram_wmask) begin
            mem[sram_addr] <= sram_din;
            sram_dout      <= DW'($urandom);
        end else begin
            sram_dout <= mem[sram_addr];
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [DEPTH];
    int            next_port;
    bit            exp_pend;
    int            exp_port;
    logic [DW-1:0] exp_data;
    logic [AW-1:0] exp_held_addr;
    logic [DW-1:0] exp_held_din;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input bit v0, input bit we0, input int a0, input logic [DW-1:0] d0,
                         input bit v1, input bit we1, input int a1, input logic [DW-1:0] d1);
        p0_req_valid = v0; p0_req_we = we0; p0_req_addr = AW'(a0); p0_req_wdata = d0;
        p1_req_valid = v1; p1_req_we = we1; p1_req_addr = AW'(a1); p1_req_wdata = d1;
    endtask

    task automatic idle();
        drive(0, 0, 0, '0, 0, 0, 0, '0);
    endtask

    task automatic model_reset();
        next_port     = 0;
        exp_pend      = 0;
        exp_port      = 0;
        exp_data      = '0;
        exp_held_addr = '0;
        exp_held_din  = '0;
    endtask

    // One clock: check all outputs mid-cycle against the model, advance the model, return 1 after the edge
    task automatic step();
        int            win;
        int            prio;
        bit            w_we;
        logic [AW-1:0] w_addr;
        logic [DW-1:0] w_data;
        @(negedge clk);
`ifdef SRAM22_ARB_FIXED_PRIO_EN
        prio = 0;
`else
        prio = next_port;
`endif
        if (p0_req_valid && p1_req_valid) win = prio;
        else if (p0_req_valid)             win = 0;
        else if (p1_req_valid)             win = 1;
        else                               win = -1;
        w_we   = (win == 0) ? p0_req_we : (win == 1) ? p1_req_we : 1'b0;
        w_addr = (win == 0) ? p0_req_addr : (win == 1) ? p1_req_addr : exp_held_addr;
        w_data = (win == 0) ? p0_req_wdata : (win == 1) ? p1_req_wdata : exp_held_din;

        check("p0_ready", 32'(p0_req_ready), 32'(win == 0));
        check("p1_ready", 32'(p1_req_ready), 32'(win == 1));
        check("sram_we", 32'(sram_we), 32'(w_we));
        check("sram_wmask", 32'(sram_wmask), 32'(w_we));
        check("sram_addr", 32'(sram_addr), 32'(w_addr));
        check("sram_din", 32'(sram_din), 32'(w_data));
        check("p0_rsp_valid", 32'(p0_rsp_valid), 32'(exp_pend && exp_port == 0));
        check("p1_rsp_valid", 32'(p1_rsp_valid), 32'(exp_pend && exp_port == 1));
        check("p0_rsp_rdata", 32'(p0_rsp_rdata), (exp_pend && exp_port == 0) ? 32'(exp_data) : 32'd0);
        check("p1_rsp_rdata", 32'(p1_rsp_rdata), (exp_pend && exp_port == 1) ? 32'(exp_data) : 32'd0);

        exp_pend = 0;
        if (win >= 0) begin
            if (w_we) begin
                ref_mem[w_addr] = w_data;
            end else begin
                exp_pend = 1;
                exp_port = win;
                exp_data = ref_mem[w_addr];
            end
            exp_held_addr = w_addr;
            exp_held_din  = w_data;
            next_port     = 1 - win;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        rst_n = 1'b0;
        idle();
        model_reset();
        step();
        step();
        rst_n = 1'b1;
        step();

        // Reset in the middle of a read: the response is dropped and the pointer returns to port 0
        drive(1, 0, 5, '0, 0, 0, 0, '0);
        step();
        rst_n = 1'b0;
        model_reset();
        idle();
        #1;
        check("rst_p0_rsp_valid", 32'(p0_rsp_valid), 32'd0);
        check("rst_sram_we", 32'(sram_we), 32'd0);
        step();
        rst_n = 1'b1;
        drive(1, 0, 1, '0, 1, 0, 2, '0);
        step();
        idle();
        step();

        // Write then cross-port read of the same address
        drive(1, 1, 5, 24'hABCDEF, 0, 0, 0, '0);
        step();
        drive(0, 0, 0, '0, 1, 0, 5, '0);
        step();
        idle();
        check("t2_p1_rsp_valid", 32'(p1_rsp_valid), 32'd1);
        check("t2_p1_rsp_rdata", 32'(p1_rsp_rdata), 32'hABCDEF);
        step();

        // Both ports reading every cycle
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, $urandom_range(DEPTH - 1), '0, 1, 0, $urandom_range(DEPTH - 1), '0);
            step();
        end
        idle();
        step();

        // p0 write contends with p1 read right after a p0 grant
        drive(1, 0, 5, '0, 0, 0, 0, '0);
        step();
        drive(1, 1, 9, 24'h123456, 1, 0, 5, '0);
        step();
        drive(1, 1, 9, 24'h123456, 0, 0, 0, '0);
        step();
        idle();
        step();
        step();

        // Fill every address from alternating ports, then read all back
        for (int i = 0; i < DEPTH; i++) begin
            if (i % 2 == 0) drive(1, 1, i, DW'(i * 24'h010101), 0, 0, 0, '0);
            else            drive(0, 0, 0, '0, 1, 1, i, DW'(i * 24'h010101));
            step();
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (i % 2 == 0) drive(1, 0, i, '0, 0, 0, 0, '0);
            else            drive(0, 0, 0, '0, 1, 0, i, '0);
            step();
            idle();
            if (i % 2 == 0) check("fill_p0_rdata", 32'(p0_rsp_rdata), 32'(i * 24'h010101));
            else            check("fill_p1_rdata", 32'(p1_rsp_rdata), 32'(i * 24'h010101));
        end
        step();

        // Random traffic, addresses often clustered to provoke read-after-write hits
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(9) < 7, $urandom_range(1) == 1,
                  ($urandom_range(1) == 1) ? $urandom_range(7) : $urandom_range(DEPTH - 1), DW'($urandom),
                  $urandom_range(9) < 7, $urandom_range(1) == 1,
                  ($urandom_range(1) == 1) ? $urandom_range(7) : $urandom_range(DEPTH - 1), DW'($urandom));
            step();
        end
        idle();
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
